// File: rtl/fifo_uart_pkg.sv
// Shared types and line-level constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic TX_IDLE   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fifo_uart_parity_calc.sv
// Frame parity generator for the UART transmitter.
// Only present when FIFO_UART_PARITY_EN is defined.
`ifdef FIFO_UART_PARITY_EN
module parity_calc
    import fifo_uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             parity
);

    // Even parity is the XOR of the data bits; odd parity inverts it.
    assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule
`endif

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one word per frame and shifts it out
// LSB-first as start / data / [parity] / stop, one bit per CLK.
// Optional feature: FIFO_UART_PARITY_EN adds the PAR_TYP port and a parity bit.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EMPTY,
    input  logic [WIDTH-1:0] RD_DATA,
`ifdef FIFO_UART_PARITY_EN
    input  logic             PAR_TYP,
`endif
    output logic             R_INC,
    output logic             TX_OUT,
    output logic             BUSY
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             tx_q,    tx_d;
    logic             busy_q,  busy_d;
    logic             pop;

`ifdef FIFO_UART_PARITY_EN
    logic par_q, par_d;
    logic par_bit;

    parity_calc #(
        .WIDTH (WIDTH)
    ) u_parity_calc (
        .data    (RD_DATA),
        .par_typ (PAR_TYP),
        .parity  (par_bit)
    );
`endif

    // A word is taken only between frames (IDLE) or on the stop bit (STOP).
    assign pop = ((state_q == IDLE) || (state_q == STOP)) && !EMPTY;

    // Gated with reset so no pop strobe escapes while the FSM is held in reset.
    assign R_INC  = pop & RST;
    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

    // Next-state, datapath and registered-output decode.
    // TX_OUT is registered, so tx_d carries the bit belonging to state_d.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
`ifdef FIFO_UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE, STOP: begin
                if (pop) begin
                    state_d = START;
                    shreg_d = RD_DATA;
`ifdef FIFO_UART_PARITY_EN
                    par_d   = par_bit;
`endif
                    tx_d    = START_BIT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    tx_d    = TX_IDLE;
                    busy_d  = 1'b0;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                tx_d    = shreg_q[0];
                shreg_d = shreg_q >> 1;
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
`ifdef FIFO_UART_PARITY_EN
                    state_d = PARITY;
                    tx_d    = par_q;
`else
                    state_d = STOP;
                    tx_d    = STOP_BIT;
`endif
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
`ifdef FIFO_UART_PARITY_EN
            PARITY: begin
                state_d = STOP;
                tx_d    = STOP_BIT;
            end
`endif
            default: begin
                state_d = IDLE;
                tx_d    = TX_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state and registered line outputs; reset drives the line idle at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            tx_q    <= TX_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Shift register, bit counter and latched parity bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef FIFO_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef FIFO_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed testbench for fifo_uart_tx (default build or FIFO_UART_PARITY_EN).
module tb_fifo_uart_tx;

`ifdef FIFO_UART_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned NO_DROP = 99;

    logic       clk;
    logic       rst_n;
    logic       use_fifo;
    logic       dir_empty;
    logic [7:0] dir_data;
    logic       f_empty;
    logic [7:0] f_rd;
    logic       empty_in;
    logic [7:0] rd_in;
    logic       r_inc;
    logic       tx;
    logic       busy;
`ifdef FIFO_UART_PARITY_EN
    logic       par_typ;
`endif

    logic [7:0] fq[$];
    int         pops;
    int         pop_on_empty;
    int         vectors;
    int         miscompares;
    int         base_pops;

    assign empty_in = use_fifo ? f_empty : dir_empty;
    assign rd_in    = use_fifo ? f_rd    : dir_data;

    fifo_uart_tx #(
        .WIDTH (8),
        .CNT_W (3)
    ) dut (
        .CLK     (clk),
        .RST     (rst_n),
        .EMPTY   (empty_in),
        .RD_DATA (rd_in),
`ifdef FIFO_UART_PARITY_EN
        .PAR_TYP (par_typ),
`endif
        .R_INC   (r_inc),
        .TX_OUT  (tx),
        .BUSY    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO read side: registered EMPTY and head-of-queue data.
    initial begin
        pops         = 0;
        pop_on_empty = 0;
        f_empty      = 1'b1;
        f_rd         = 8'h00;
    end
    always @(posedge clk) begin
        if (use_fifo && r_inc) begin
            if (fq.size() == 0) pop_on_empty++;
            else begin
                void'(fq.pop_front());
                pops++;
            end
        end
        f_empty <= (fq.size() == 0);
        f_rd    <= (fq.size() != 0) ? fq[0] : 8'h00;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame in send order: bit0 = start, then data LSB-first, [parity], stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p);
`ifdef FIFO_UART_PARITY_EN
        mk_frame = {1'b1, p, d, 1'b0};
`else
        mk_frame = {p, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic push(input logic [7:0] w);
        fq.push_back(w);
    endtask

    task automatic check_frame(input logic [10:0] frame, input logic last_rinc,
                               input int unsigned drop_at);
        for (int unsigned i = 0; i < FRAME_BITS; i++) begin
            @(negedge clk);
            chk($sformatf("bit%0d", i), tx, frame[i]);
            chk("busy", busy, 1'b1);
            chk("rinc", r_inc, (i == FRAME_BITS - 1) ? last_rinc : 1'b0);
            if (i == drop_at) begin
                dir_empty = 1'b1;
                dir_data  = 8'h5A;
            end
`ifdef FIFO_UART_PARITY_EN
            if (i == 2) par_typ = ~par_typ;
`endif
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"},   tx,    1'b1);
        chk({tag, "_busy"}, busy,  1'b0);
        chk({tag, "_rinc"}, r_inc, 1'b0);
    endtask

    initial begin
        logic [7:0] w6 [8];
        w6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        use_fifo    = 1'b0;
        dir_empty   = 1'b0;
        dir_data    = 8'h00;
`ifdef FIFO_UART_PARITY_EN
        par_typ     = 1'b0;
`endif

        // Reset state, with EMPTY low to show no pop leaks during reset.
        repeat (2) @(negedge clk);
        chk_idle("rst");
        dir_empty = 1'b1;
        rst_n     = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");

        // Reset mid-frame: line returns idle immediately.
        dir_data  = 8'h96;
        dir_empty = 1'b0;
        #1 chk("t1_pop", r_inc, 1'b1);
        @(negedge clk);
        chk("t1_start", tx, 1'b0);
        chk("t1_busy", busy, 1'b1);
        dir_empty = 1'b1;
        @(negedge clk);
        chk("t1_d0", tx, 1'b0);
        @(negedge clk);
        chk("t1_d1", tx, 1'b1);
        rst_n     = 1'b0;
        dir_empty = 1'b0;
        #1 chk_idle("t1_async");
        @(negedge clk);
        dir_empty = 1'b1;
        rst_n     = 1'b1;
        @(negedge clk);
        chk_idle("t1_release");

        // EMPTY rises during DATA: frame completes, no pop at STOP.
        dir_data  = 8'hC3;
        dir_empty = 1'b0;
        #1 chk("t5_pop", r_inc, 1'b1);
        check_frame(mk_frame(8'hC3, 1'b0), 1'b0, 4);
        @(negedge clk);
        chk_idle("t5_idle");

`ifdef FIFO_UART_PARITY_EN
        // Parity: latched at pop edge, unaffected by later PAR_TYP toggles.
        par_typ   = 1'b0;
        dir_data  = 8'h07;
        dir_empty = 1'b0;
        #1 chk("t4e_pop", r_inc, 1'b1);
        check_frame(mk_frame(8'h07, 1'b1), 1'b0, 3);
        @(negedge clk);
        chk_idle("t4e_idle");
        par_typ   = 1'b1;
        dir_data  = 8'h07;
        dir_empty = 1'b0;
        #1 chk("t4o_pop", r_inc, 1'b1);
        check_frame(mk_frame(8'h07, 1'b0), 1'b0, 3);
        @(negedge clk);
        chk_idle("t4o_idle");
        par_typ = 1'b0;
`endif

        // Single word through the FIFO model.
        use_fifo = 1'b1;
        push(8'hA5);
        @(negedge clk);
        chk("t2_pop", r_inc, 1'b1);
        chk("t2_idle_tx", tx, 1'b1);
        chk("t2_idle_busy", busy, 1'b0);
        check_frame(mk_frame(8'hA5, 1'b0), 1'b0, NO_DROP);
        @(negedge clk);
        chk_idle("t2_idle");

        // Back-to-back: pops exactly one frame apart, no idle bit.
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        @(negedge clk);
        chk("t3_pop", r_inc, 1'b1);
        check_frame(mk_frame(8'h00, 1'b0), 1'b1, NO_DROP);
        check_frame(mk_frame(8'hFF, 1'b0), 1'b1, NO_DROP);
        check_frame(mk_frame(8'h3C, 1'b0), 1'b0, NO_DROP);
        @(negedge clk);
        chk_idle("t3_idle");

        // End-to-end: 8 words written at three per read clock, sent in order.
        base_pops = pops;
        fork
            begin
                #1;
                for (int unsigned k = 0; k < 8; k++) begin
                    push(w6[k]);
                    #3;
                end
            end
            begin
                @(negedge clk);
                chk("t6_pop", r_inc, 1'b1);
                for (int unsigned k = 0; k < 8; k++)
                    check_frame(mk_frame(w6[k], 1'b0), (k < 7) ? 1'b1 : 1'b0, NO_DROP);
            end
        join
        @(negedge clk);
        chk_idle("t6_idle");
        chk("t6_empty", f_empty, 1'b1);
        chk("t6_pops", pops - base_pops, 8);
        chk("t6_pop_on_empty", pop_on_empty, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
